uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, LSB first, optional even-parity bit before the stop bit.
// Build option: define UART_RX_PARITY_EN to receive and check the parity bit; otherwise data goes straight to stop.
module uart_rx #(
    parameter int Data_bits = 9,
    parameter int St_ticks  = 8,
    parameter int Dt_ticks  = 16
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 rx,
    input  logic                 s_ticks,
    output logic [Data_bits-2:0] data_out,
    output logic                 rx_done_tick,
    output logic                 parity_error,
    output logic                 frame_error
);
    localparam int DW = Data_bits - 1;
    localparam int SW = $clog2(Dt_ticks);
    localparam int NW = $clog2(Data_bits);
    localparam logic [SW-1:0] S_MID  = SW'(St_ticks / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(Dt_ticks - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DW - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_reg;
    logic [SW-1:0] s_reg;
    logic [NW-1:0] n_reg;
    logic [DW-1:0] shift_reg;
    logic [DW-1:0] data_reg;
    logic          armed_reg;
    logic          done_reg;
    logic          frame_err_reg;
`ifdef UART_RX_PARITY_EN
    // Parity result is held here until the stop bit commits the whole frame.
    logic          parity_pend_reg;
    logic          parity_err_reg;
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            s_reg         <= '0;
            n_reg         <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            armed_reg     <= 1'b0;
            done_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_pend_reg <= 1'b0;
            parity_err_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A line that has not been seen high since a break stays ignored.
                    if (rx) begin
                        armed_reg <= 1'b1;
                    end else if (armed_reg) begin
                        s_reg     <= '0;
                        state_reg <= START;
                    end
                end
                START: if (s_ticks) begin
                    if (s_reg == S_MID) begin
                        if (!rx) begin
                            s_reg     <= '0;
                            n_reg     <= '0;
                            state_reg <= DATA;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        s_reg <= s_reg + SW'(1);
                    end
                end
                DATA: if (s_ticks) begin
                    if (s_reg == S_LAST) begin
                        s_reg     <= '0;
                        shift_reg <= {rx, shift_reg[DW-1:1]};
                        n_reg     <= n_reg + NW'(1);
                        if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end
                    end else begin
                        s_reg <= s_reg + SW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (s_ticks) begin
                    if (s_reg == S_LAST) begin
                        s_reg           <= '0;
                        parity_pend_reg <= rx ^ (^shift_reg);
                        state_reg       <= STOP;
                    end else begin
                        s_reg <= s_reg + SW'(1);
                    end
                end
`endif
                STOP: if (s_ticks) begin
                    if (s_reg == S_LAST) begin
                        s_reg         <= '0;
                        data_reg      <= shift_reg;
                        frame_err_reg <= ~rx;
                        done_reg      <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_reg <= parity_pend_reg;
`endif
                        if (!rx) begin
                            armed_reg <= 1'b0;
                        end
                        state_reg <= IDLE;
                    end else begin
                        s_reg <= s_reg + SW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign data_out     = data_reg;
    assign rx_done_tick = done_reg;
    assign frame_error  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_err_reg;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; frames are queued when driven and checked on rx_done_tick.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int DB = 9;
    localparam int DW = DB - 1;
    localparam int ST = 8;
    localparam int DT = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAT = ST / 2 + DT * (DW + PAR) + DT;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          rx = 1'b1;
    logic          s_ticks = 1'b0;
    logic [DW-1:0] data_out;
    logic          rx_done_tick;
    logic          parity_error;
    logic          frame_error;

    uart_rx #(.Data_bits(DB), .St_ticks(ST), .Dt_ticks(DT)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .rx           (rx),
        .s_ticks      (s_ticks),
        .data_out     (data_out),
        .rx_done_tick (rx_done_tick),
        .parity_error (parity_error),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        int unsigned   t0;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad = 0;
    int            done_n = 0;
    int unsigned   tick_n = 0;
    logic [DW-1:0] last_data = '0;
    logic          last_perr = 1'b0;
    logic          last_ferr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // s_ticks: one clk in every four, changed just after the edge.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt = (cnt + 1) % 4;
            s_ticks = (cnt == 0);
        end
    end

    always @(posedge clk) if (s_ticks) tick_n <= tick_n + 1;

    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_n++;
            if (sb.size() == 0) begin
                check_eq("unexpected_tick", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("frame: data=%02h perr=%0b ferr=%0b latency=%0d", data_out, parity_error,
                         frame_error, tick_n - mon_e.t0);
                check_eq("data_out", 32'(data_out), 32'(mon_e.data));
                check_eq("parity_error", 32'(parity_error), 32'(mon_e.perr));
                check_eq("frame_error", 32'(frame_error), 32'(mon_e.ferr));
                check_eq("latency", tick_n - mon_e.t0, LAT);
                last_data = mon_e.data;
                last_perr = mon_e.perr;
                last_ferr = mon_e.ferr;
            end
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (s_ticks) k++;
        end
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par_bit, input logic stop_bit,
                              input logic exp_perr);
        exp_t e;
        rx = 1'b0;
        e.data = d;
        e.perr = exp_perr;
        e.ferr = ~stop_bit;
        e.t0   = tick_n;
        sb.push_back(e);
        wait_ticks(ST);
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            wait_ticks(DT);
        end
        if (PAR == 1) begin
            rx = par_bit;
            wait_ticks(DT);
        end
        rx = stop_bit;
        wait_ticks(DT);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_done", 32'(rx_done_tick), 32'd0);
        check_eq("rst_perr", 32'(parity_error), 32'd0);
        check_eq("rst_ferr", 32'(frame_error), 32'd0);
        Reset = 1'b0;
        wait_ticks(4);

        d = 8'hA5;
        send_frame(d, ^d, 1'b1, 1'b0);
        wait_ticks(3);

        // Wrong parity bit; a build without parity sends none and expects no error.
        d = 8'h01;
        send_frame(d, 1'b0, 1'b1, (PAR == 1) ? 1'b1 : 1'b0);
        wait_ticks(5);

        rx = 1'b0;
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(10);
        check_eq("glitch_data", 32'(data_out), 32'(last_data));
        check_eq("glitch_perr", 32'(parity_error), 32'(last_perr));
        check_eq("glitch_ferr", 32'(frame_error), 32'(last_ferr));

        // 8'hFF aborted by reset in the middle of bit 4.
        rx = 1'b0;
        wait_ticks(ST);
        rx = 1'b1;
        wait_ticks(4 * DT + DT / 2);
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        check_eq("abort_data", 32'(data_out), 32'd0);
        check_eq("abort_perr", 32'(parity_error), 32'd0);
        check_eq("abort_ferr", 32'(frame_error), 32'd0);
        wait_ticks(20);
        d = 8'h55;
        send_frame(d, ^d, 1'b1, 1'b0);

        d = 8'h00;
        send_frame(d, ^d, 1'b1, 1'b0);
        d = 8'hFF;
        send_frame(d, ^d, 1'b1, 1'b0);
        wait_ticks(6);

        // Stop bit low followed by a long break: only one frame may be reported.
        d = 8'h3C;
        send_frame(d, ^d, 1'b0, 1'b0);
        wait_ticks(40 * DT);
        check_eq("break_frames", done_n, 32'd6);
        rx = 1'b1;
        wait_ticks(2 * DT);

        d = 8'h5A;
        send_frame(d, ^d, 1'b1, 1'b0);
        wait_ticks(20);

        check_eq("queue_empty", sb.size(), 32'd0);
        check_eq("done_count", done_n, 32'd7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
